// File: rtl/intc6.sv
// ---------------------------------------------------------------------------
// intc6 -- six-source interrupt controller feeding the CPU hwint[5:0] input.
//
// Each device request is captured as an edge event or tracked as a level.
// A software mask gates the captured requests, and the result is registered
// onto hwint. A four-word register window on the device bus lets the handler
// identify, acknowledge and mask sources.
//
// Optional feature (compile-time macro):
//   INTC_SYNC_EN  adds a 2-flop synchronizer on every irq_src bit, for
//                 asynchronous sources. This adds two cycles of latency.
//                 When the macro is undefined, irq_src is sampled directly.
//
// Ports:
//   clk      in   1   system clock, rising edge active
//   rst      in   1   asynchronous reset, active low
//   irq_src  in   6   raw device requests, active high; bit i -> hwint[i]
//   sel      in   1   bridge chip-select for this register window
//   we       in   1   write strobe, qualified by sel
//   addr     in   2   word offset: 0 PEND, 1 MASK, 2 MODE, 3 VEC
//   wdata    in  32   write data, bits [5:0] used
//   rdata    out 32   combinational read data selected by addr
//   hwint    out  6   registered PEND & MASK, to CP0
//
// Bus access semantics: the window has no handshake. An access is one cycle.
// A write takes effect at the rising edge where sel and we are both high.
// A read is combinational from addr and has no side effects. Cycles without
// sel change nothing.
// ---------------------------------------------------------------------------
module intc6 (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq_src,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  hwint
);

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_VEC  = 2'd3;

    logic [5:0] s;          // sampled source
    logic [5:0] s_d;        // s delayed one cycle
    logic [5:0] rise;       // rising-edge events this cycle
    logic [5:0] pend;
    logic [5:0] mask;
    logic [5:0] mode;       // 0 = edge, 1 = level
    logic [5:0] pend_w1c;
    logic [5:0] pend_next;
    logic [5:0] active;
    logic [2:0] vec_idx;
    logic       wr_en;

    // Only wdata[5:0] carries register bits.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:6];

`ifdef INTC_SYNC_EN
    logic [5:0] sync_q1;
    logic [5:0] sync_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = irq_src;
`endif

    assign rise     = s & ~s_d;
    assign wr_en    = sel & we;
    assign pend_w1c = (wr_en && addr == ADDR_PEND) ? wdata[5:0] : 6'd0;
    assign active   = pend & mask;

    // Level bits follow the source and ignore software clears.
    // Edge bits are set by a new edge. The set term is ORed in after the
    // clear, so an edge that arrives during an acknowledge is kept.
    assign pend_next = (mode & s) | (~mode & (rise | (pend & ~pend_w1c)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d   <= '0;
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            hwint <= '0;
        end else begin
            s_d   <= s;
            pend  <= pend_next;
            // Uses the PEND and MASK values from before this edge, so a mask
            // write is seen on hwint one edge later.
            hwint <= active;
            if (wr_en && addr == ADDR_MASK) begin
                mask <= wdata[5:0];
            end
            if (wr_en && addr == ADDR_MODE) begin
                mode <= wdata[5:0];
            end
        end
    end

    // Lowest active index wins. The loop runs downwards so the last
    // assignment is the lowest set bit.
    always_comb begin
        vec_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 3'(i);
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_PEND: rdata[5:0] = pend;
            ADDR_MASK: rdata[5:0] = mask;
            ADDR_MODE: rdata[5:0] = mode;
            ADDR_VEC: begin
                rdata[31]  = |active;
                rdata[2:0] = vec_idx;
            end
            default:   rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_intc6.sv
// ---------------------------------------------------------------------------
// tb_intc6 -- self-checking bench for intc6 (default build, no synchronizer).
//
// A reference model of the register file follows the bus and source activity.
// It is checked against hwint and rdata one delta after every rising edge.
// Directed sequences add hand-computed literal checks on the points the
// design must hit exactly.
// ---------------------------------------------------------------------------
module tb_intc6;

    logic        clk;
    logic        rst;
    logic [5:0]  irq_src;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hwint;

    int total = 0;
    int bad   = 0;

    intc6 dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .hwint   (hwint)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] m_pend;
    logic [5:0] m_mask;
    logic [5:0] m_mode;
    logic [5:0] m_prev;       // source value seen at the previous edge
    logic [5:0] exp_q[$];     // hwint values awaiting their output edge

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        logic [5:0]  act;
        r   = 32'd0;
        act = m_pend & m_mask;
        case (a)
            2'd0: r = {26'd0, m_pend};
            2'd1: r = {26'd0, m_mask};
            2'd2: r = {26'd0, m_mode};
            default: begin
                if (act != 6'd0) begin
                    r = 32'h8000_0000;
                    for (int i = 0; i < 6; i++) begin
                        if (act[i]) begin
                            r[2:0] = 3'(i);
                            break;
                        end
                    end
                end
            end
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        logic [5:0] clr;
        logic [5:0] np;
        logic [5:0] exp_h;
        if (!rst) begin
            m_pend = '0;
            m_mask = '0;
            m_mode = '0;
            m_prev = '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(m_pend & m_mask);
            clr = (sel && we && addr == 2'd0) ? wdata[5:0] : 6'd0;
            for (int i = 0; i < 6; i++) begin
                if (m_mode[i])                       np[i] = irq_src[i];
                else if (irq_src[i] && !m_prev[i])   np[i] = 1'b1;
                else if (clr[i])                     np[i] = 1'b0;
                else                                 np[i] = m_pend[i];
            end
            if (sel && we && addr == 2'd1) m_mask = wdata[5:0];
            if (sel && we && addr == 2'd2) m_mode = wdata[5:0];
            m_prev = irq_src;
            m_pend = np;
        end
        #1;
        exp_h = (exp_q.size() > 0) ? exp_q.pop_front() : 6'd0;
        check("cyc_hwint", {26'd0, hwint}, {26'd0, exp_h});
        check("cyc_rdata", rdata, model_read(addr));
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    endtask

    task automatic rd_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; addr = a;
        #1;
        check(name, rdata, exp);
        sel = 1'b0; addr = 2'd0;
    endtask

    task automatic hw_expect(input string name, input logic [5:0] exp);
        check(name, {26'd0, hwint}, {26'd0, exp});
    endtask

    logic [5:0] pats [8];

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b0; irq_src = 6'h3F; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;

        // Reset held with all sources high.
        tick(3);
        hw_expect("rst_hwint", 6'h00);
        rd_expect("rst_pend", 2'd0, 32'd0);
        rd_expect("rst_mask", 2'd1, 32'd0);
        rd_expect("rst_mode", 2'd2, 32'd0);
        rd_expect("rst_vec",  2'd3, 32'd0);

        // Release: high sources look like edges, mask still 0.
        rst = 1'b1;
        tick(2);
        rd_expect("rel_pend", 2'd0, 32'h3F);
        hw_expect("rel_hwint", 6'h00);

        irq_src = 6'h00;
        bus_wr(2'd0, 32'h3F);
        rd_expect("clr_all", 2'd0, 32'h00);

        // Edge capture of a one-cycle pulse, then acknowledge.
        bus_wr(2'd1, 32'h04);
        bus_wr(2'd2, 32'h00);
        irq_src = 6'h04;
        tick(1);
        irq_src = 6'h00;
        hw_expect("edge_lat0", 6'h00);
        rd_expect("edge_pend", 2'd0, 32'h04);
        tick(1);
        hw_expect("edge_lat1", 6'h04);
        tick(3);
        hw_expect("edge_held", 6'h04);
        bus_wr(2'd0, 32'h04);
        hw_expect("ack_edge", 6'h04);
        rd_expect("ack_pend", 2'd0, 32'h00);
        tick(1);
        hw_expect("ack_next", 6'h00);

        // Set/clear collision on bit 1.
        bus_wr(2'd1, 32'h02);
        irq_src = 6'h02;
        tick(1);
        irq_src = 6'h00;
        tick(1);
        rd_expect("coll_pre", 2'd0, 32'h02);
        irq_src = 6'h02;
        sel = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h02;
        tick(1);
        sel = 1'b0; we = 1'b0; wdata = 32'd0;
        irq_src = 6'h00;
        rd_expect("coll_pend", 2'd0, 32'h02);
        hw_expect("coll_hwint", 6'h02);
        bus_wr(2'd0, 32'h02);
        rd_expect("coll_clr", 2'd0, 32'h00);

        // Accesses without sel, and writes to VEC, are ignored.
        we = 1'b1; addr = 2'd1; wdata = 32'h3F;
        tick(1);
        we = 1'b0; addr = 2'd0; wdata = 32'd0;
        rd_expect("nosel_mask", 2'd1, 32'h02);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        rd_expect("vec_wr_ign", 2'd3, 32'h0);

        // Level mode on bit 5.
        bus_wr(2'd2, 32'h20);
        bus_wr(2'd1, 32'h20);
        irq_src = 6'h20;
        tick(2);
        hw_expect("lvl_on", 6'h20);
        bus_wr(2'd0, 32'h20);
        tick(1);
        hw_expect("lvl_w1c_ign", 6'h20);
        rd_expect("lvl_pend", 2'd0, 32'h20);
        irq_src = 6'h00;
        tick(1);
        hw_expect("lvl_off_lat0", 6'h20);
        rd_expect("lvl_pend_off", 2'd0, 32'h00);
        tick(1);
        hw_expect("lvl_off_lat1", 6'h00);

        // Priority encoding.
        bus_wr(2'd2, 32'h00);
        irq_src = 6'h2A;
        tick(1);
        irq_src = 6'h00;
        bus_wr(2'd1, 32'h28);
        rd_expect("pri_pend", 2'd0, 32'h2A);
        rd_expect("pri_vec28", 2'd3, 32'h8000_0003);
        bus_wr(2'd1, 32'h00);
        rd_expect("pri_vec0", 2'd3, 32'h0000_0000);
        bus_wr(2'd1, 32'h3F);
        rd_expect("pri_vec3f", 2'd3, 32'h8000_0001);
        tick(1);
        hw_expect("pri_hwint", 6'h2A);

        // Mid-operation reset discards everything at once.
        rst = 1'b0;
        #1;
        hw_expect("mid_rst_hwint", 6'h00);
        rd_expect("mid_rst_pend", 2'd0, 32'h00);
        rd_expect("mid_rst_mask", 2'd1, 32'h00);
        tick(1);
        rst = 1'b1;
        tick(2);
        hw_expect("post_rst_hwint", 6'h00);

        // Mixed edge/level traffic, checked cycle by cycle against the model.
        pats[0] = 6'h01; pats[1] = 6'h03; pats[2] = 6'h00; pats[3] = 6'h3F;
        pats[4] = 6'h3F; pats[5] = 6'h10; pats[6] = 6'h00; pats[7] = 6'h2C;
        bus_wr(2'd1, 32'h3F);
        bus_wr(2'd2, 32'h15);
        for (int i = 0; i < 8; i++) begin
            irq_src = pats[i];
            addr = 2'(i);
            tick(1);
        end
        addr = 2'd0;
        bus_wr(2'd0, 32'h3F);
        irq_src = 6'h00;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
